// File: rtl/alu_operand_sequencer_if.sv
// Handshake/data bundle between the decoder, the operand mux/ALU and the sequencer.
interface alu_operand_sequencer_if #(
  parameter int WIDTH = 17
);
  logic             Start;
  logic [3:0]       Opcode;
  logic             Hold;
  logic [WIDTH-1:0] Result;
  logic [3:0]       Selection;
  logic             Busy;
  logic             Done;
  logic             Error;
  logic [WIDTH-1:0] ResultOut;

  modport master (
    output Start, Opcode, Hold, Result,
    input  Selection, Busy, Done, Error, ResultOut
  );

  modport slave (
    input  Start, Opcode, Hold, Result,
    output Selection, Busy, Done, Error, ResultOut
  );
endinterface

// File: rtl/alu_operand_sequencer.sv
// Walks a per-opcode list of operand-select codes and accumulates the ALU
// result sampled at the end of each step; pulses Done when the list ends.
module alu_operand_sequencer #(
  parameter int         WIDTH    = 17,
  parameter logic [3:0] SEL_IDLE = 4'd6
) (
  input logic                     Clock,
  input logic                     Reset_n,
  alu_operand_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_state;
  logic [3:0]       r_op;
  logic [1:0]       r_step;
  logic [3:0]       r_sel;
  logic             r_busy;
  logic             r_done;
  logic             r_err;
  logic [WIDTH-1:0] r_acc;

  function automatic logic legal(input logic [3:0] op);
    return op <= 4'd5;
  endfunction

  function automatic logic [1:0] last_step(input logic [3:0] op);
    case (op)
      4'd2:    return 2'd1;
      4'd5:    return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

  function automatic logic [3:0] seq_code(input logic [3:0] op, input logic [1:0] idx);
    case (op)
      4'd0:    return 4'd1;
      4'd1:    return 4'd2;
      4'd2:    return (idx == 2'd0) ? 4'd3 : 4'd4;
      4'd3:    return 4'd5;
      4'd4:    return 4'd6;
      4'd5:    return (idx == 2'd0) ? 4'd0 : (idx == 2'd1) ? 4'd1 : 4'd2;
      default: return SEL_IDLE;
    endcase
  endfunction

  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      r_state <= S_IDLE;
      r_op    <= '0;
      r_step  <= '0;
      r_sel   <= SEL_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_acc   <= '0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_busy <= 1'b0;
          r_sel  <= SEL_IDLE;
          if (bus.Start) begin
            if (legal(bus.Opcode)) begin
              r_op    <= bus.Opcode;
              r_step  <= 2'd0;
              r_sel   <= seq_code(bus.Opcode, 2'd0);
              r_busy  <= 1'b1;
              r_state <= S_RUN;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (!bus.Hold) begin
            // First step overwrites so a new sequence never inherits the old total.
            r_acc <= (r_step == 2'd0) ? bus.Result : r_acc + bus.Result;
            if (r_step == last_step(r_op)) begin
              r_sel   <= SEL_IDLE;
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_step <= r_step + 2'd1;
              r_sel  <= seq_code(r_op, r_step + 2'd1);
            end
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.Selection = r_sel;
  assign bus.Busy      = r_busy;
  assign bus.Done      = r_done;
  assign bus.Error     = r_err;
  assign bus.ResultOut = r_acc;

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Directed bench: the operand mux is modelled from Selection, outputs are checked
// 1 time unit after each rising edge against hand-computed values.
module tb_alu_operand_sequencer;
  localparam int WIDTH = 17;

  logic Clock = 1'b0;
  logic Reset_n;
  logic [WIDTH-1:0] in1, in2;
  int n_chk = 0;
  int n_fail = 0;

  alu_operand_sequencer_if #(.WIDTH(WIDTH)) bus ();

  alu_operand_sequencer #(.WIDTH(WIDTH), .SEL_IDLE(4'd6)) dut (
    .Clock   (Clock),
    .Reset_n (Reset_n),
    .bus     (bus.slave)
  );

  always #5 Clock = ~Clock;

  always_comb begin
    case (bus.Selection)
      4'd0:    bus.Result = in1;
      4'd1:    bus.Result = in2;
      4'd2:    bus.Result = 17'd1;
      4'd3:    bus.Result = 17'd96;
      4'd4:    bus.Result = 17'd97;
      4'd5:    bus.Result = 17'd144;
      default: bus.Result = 17'd0;
    endcase
  end

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    in1 = 17'h1FFFF;
    in2 = 17'h00002;
    Reset_n = 1'b0;
    bus.Start = 1'b0;
    bus.Opcode = 4'd0;
    bus.Hold = 1'b0;
    tick(); tick();
    chk("rst_sel", 32'(bus.Selection), 32'd6);
    chk("rst_busy", 32'(bus.Busy), 32'd0);
    chk("rst_acc", 32'(bus.ResultOut), 32'd0);
    Reset_n = 1'b1;
    tick();

    // Reset mid-op5 abandons the sequence
    bus.Start = 1'b1; bus.Opcode = 4'd5;
    tick(); bus.Start = 1'b0;
    chk("r5_sel0", 32'(bus.Selection), 32'd0);
    tick();
    chk("r5_sel1", 32'(bus.Selection), 32'd1);
    Reset_n = 1'b0;
    tick(); tick();
    chk("mrst_sel", 32'(bus.Selection), 32'd6);
    chk("mrst_busy", 32'(bus.Busy), 32'd0);
    chk("mrst_done", 32'(bus.Done), 32'd0);
    chk("mrst_acc", 32'(bus.ResultOut), 32'd0);
    Reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("mrst_nodone", 32'(bus.Done), 32'd0);
    end

    // op2: 96 + 97
    bus.Start = 1'b1; bus.Opcode = 4'd2;
    tick(); bus.Start = 1'b0;
    chk("op2_c1_sel", 32'(bus.Selection), 32'd3);
    chk("op2_c1_busy", 32'(bus.Busy), 32'd1);
    chk("op2_c1_done", 32'(bus.Done), 32'd0);
    tick();
    chk("op2_c2_sel", 32'(bus.Selection), 32'd4);
    chk("op2_c2_done", 32'(bus.Done), 32'd0);
    tick();
    chk("op2_c3_done", 32'(bus.Done), 32'd1);
    chk("op2_c3_busy", 32'(bus.Busy), 32'd1);
    chk("op2_c3_sel", 32'(bus.Selection), 32'd6);
    chk("op2_acc", 32'(bus.ResultOut), 32'd193);
    tick();
    chk("op2_c4_done", 32'(bus.Done), 32'd0);
    chk("op2_c4_busy", 32'(bus.Busy), 32'd0);

    // op5: wraparound accumulation
    bus.Start = 1'b1; bus.Opcode = 4'd5;
    tick(); bus.Start = 1'b0;
    chk("op5_c1_sel", 32'(bus.Selection), 32'd0);
    tick();
    chk("op5_c2_sel", 32'(bus.Selection), 32'd1);
    chk("op5_c2_acc", 32'(bus.ResultOut), 32'h1FFFF);
    tick();
    chk("op5_c3_sel", 32'(bus.Selection), 32'd2);
    chk("op5_c3_done", 32'(bus.Done), 32'd0);
    tick();
    chk("op5_c4_done", 32'(bus.Done), 32'd1);
    chk("op5_acc", 32'(bus.ResultOut), 32'h00002);
    tick();

    // op3 with two Hold cycles in step 0
    bus.Start = 1'b1; bus.Opcode = 4'd3;
    tick(); bus.Start = 1'b0; bus.Hold = 1'b1;
    chk("op3_c1_sel", 32'(bus.Selection), 32'd5);
    tick();
    chk("op3_c2_sel", 32'(bus.Selection), 32'd5);
    chk("op3_c2_done", 32'(bus.Done), 32'd0);
    tick();
    chk("op3_c3_sel", 32'(bus.Selection), 32'd5);
    chk("op3_c3_acc", 32'(bus.ResultOut), 32'h00002);
    bus.Hold = 1'b0;
    tick();
    chk("op3_c4_done", 32'(bus.Done), 32'd1);
    chk("op3_acc", 32'(bus.ResultOut), 32'd144);
    tick();

    // Illegal opcode
    bus.Start = 1'b1; bus.Opcode = 4'd9;
    tick(); bus.Start = 1'b0;
    chk("ill_err", 32'(bus.Error), 32'd1);
    chk("ill_busy", 32'(bus.Busy), 32'd0);
    chk("ill_sel", 32'(bus.Selection), 32'd6);
    chk("ill_done", 32'(bus.Done), 32'd0);
    chk("ill_acc", 32'(bus.ResultOut), 32'd144);
    tick();
    chk("ill_err_pulse", 32'(bus.Error), 32'd0);

    // Start held high (illegal opcode) while busy and in DONE: ignored
    bus.Start = 1'b1; bus.Opcode = 4'd5;
    tick(); bus.Opcode = 4'd9;
    chk("ign_c1_sel", 32'(bus.Selection), 32'd0);
    tick();
    chk("ign_c2_sel", 32'(bus.Selection), 32'd1);
    chk("ign_c2_err", 32'(bus.Error), 32'd0);
    tick();
    chk("ign_c3_sel", 32'(bus.Selection), 32'd2);
    chk("ign_c3_err", 32'(bus.Error), 32'd0);
    tick();
    chk("ign_c4_done", 32'(bus.Done), 32'd1);
    chk("ign_c4_acc", 32'(bus.ResultOut), 32'h00002);
    bus.Opcode = 4'd1;
    tick();
    chk("ign_c5_done", 32'(bus.Done), 32'd0);
    chk("ign_c5_busy", 32'(bus.Busy), 32'd0);
    chk("ign_c5_err", 32'(bus.Error), 32'd0);
    tick(); bus.Start = 1'b0;
    chk("next_sel", 32'(bus.Selection), 32'd2);
    chk("next_busy", 32'(bus.Busy), 32'd1);
    tick();
    chk("next_done", 32'(bus.Done), 32'd1);
    chk("next_acc", 32'(bus.ResultOut), 32'd1);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
